adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
- Downstream of the waveform/frequency-control stage.
- Consumes its signed sample stream over valid/ready and applies a gated attack-decay-sustain-release amplitude envelope.
- Emits scaled samples over valid/ready toward the DAC/audio output stage.
- Envelope timing runs on an internal tick divided from the system clock.

Parameters:
- width_p, 12, sample width (signed, in and out)
- env_width_p, 8, envelope level width; full scale = 2^env_width_p-1
- tick_div_p, 12000, clk cycles per envelope tick (>=1)

Ports:
- clk_i  in  1  system clock
- reset_n_i  in  1  reset; asynchronous, active-low
- gate_i  in  1  note held (1) / released (0), synchronous to clk_i
- attack_step_i  in  env_width_p  level increment per tick in ATTACK
- decay_step_i  in  env_width_p  level decrement per tick in DECAY
- sustain_level_i  in  env_width_p  sustain target level
- release_step_i  in  env_width_p  level decrement per tick in RELEASE
- valid_i  in  1  upstream sample valid
- data_i  in  width_p  upstream signed sample
- ready_o  out  1  block accepts a sample this cycle
- valid_o  out  1  output sample valid
- data_o  out  width_p  scaled signed sample
- ready_i  in  1  downstream ready
- env_state_o  out  3  current envelope state (debug)
- env_level_o  out  env_width_p  current envelope level (debug)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (reset_n_i low clears immediately, regardless of clk_i).
- Reset values: state IDLE, level 0, tick counter 0, gate_q 0, valid_o 0, data_o 0. ready_o is therefore 1.
- Reset asserted mid-operation discards any held output sample and the current envelope.
- Tick: counter runs 0..tick_div_p-1 and wraps. tick=1 in the cycle the counter equals tick_div_p-1.
- Gate edges: gate_q registers gate_i.
  - rise = gate_i & ~gate_q; fall = ~gate_i & gate_q.
  - Edges act in the cycle they are detected, independent of tick.
- States and transitions:
  - IDLE: level 0. On rise -> ATTACK.
  - ATTACK: on tick, level += attack_step_i, saturating at max. On reaching max -> DECAY.
  - DECAY: on tick, level -= decay_step_i, clamped at sustain_level_i. On reaching sustain -> SUSTAIN.
  - SUSTAIN: level tracks sustain_level_i every cycle.
  - RELEASE: on tick, level -= release_step_i, saturating at 0. On reaching 0 -> IDLE.
- Gate override rules:
  - fall in ATTACK/DECAY/SUSTAIN -> RELEASE.
  - rise in RELEASE -> ATTACK, starting from the current level (no restart from 0).
- Zero step: a step input of 0 means instant. The state's target is applied in the next cycle, the state advances, and no tick is needed. Example: attack_step=0 gives level=max and state DECAY in one cycle.
- DECAY with sustain_level_i >= level: clamp to sustain_level_i, -> SUSTAIN.
- Simultaneous events:
  - fall and a saturating tick in the same cycle: RELEASE wins; the tick's level update is still applied.
  - rise and reaching 0 in RELEASE in the same cycle: -> ATTACK.
- Datapath arithmetic:
  - product = data_i (signed) * {1'b0, level}, width width_p+env_width_p+1.
  - data_o = product >>> env_width_p, truncated to width_p.
  - No overflow is possible, because level < 2^env_width_p.
- Handshake: single output register.
  - ready_o = ~valid_o | ready_i (combinational).
  - Accept on valid_i & ready_o. The result is registered with latency 1 and uses the level value in the accept cycle.
  - valid_o stays high and data_o stays stable until ready_i.
  - Accept and drain in the same cycle gives full throughput.
  - No sample is dropped or duplicated.
- State encoding (env_state_o): IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Decomposition:
- Shared package (audio_pkg): env_state_e enum (values above) and the ENV_* state constants.
- Sub-module env_tick_gen: parameterised by tick_div_p, reset_n_i async; outputs the tick pulse. It is reusable by other timed stages.
- The FSM, level register and scaling datapath stay in adsr_envelope.

Test Plan:
- Reset: drive reset_n_i low mid-ATTACK (level 0x40) with valid_o=1, asynchronously and without a clock edge -> valid_o=0, data_o=0, env_state_o=0, env_level_o=0, ready_o=1 immediately.
- Full cycle: tick_div_p=4, attack=64, decay=16, sustain=128, release=32, gate high then low.
  - Attack levels: 64, 128, 192, 255 (ATTACK->DECAY).
  - Decay levels: 239, 223, ..., 143, 128 (->SUSTAIN).
  - After gate low, release levels: 96, 64, 32, 0 (->IDLE).
  - Each step is exactly 4 cycles apart.
- Scaling, level held at 255:
  - data_i=2047 -> data_o=2039.
  - data_i=-2048 -> data_o=-2040.
  - level 128 with data_i=-1 -> data_o=-1 (arithmetic floor).
  - level 0 -> data_o=0.
- Backpressure: continuous valid_i; ready_i low for 5 cycles, then high.
  - data_o is held stable while stalled.
  - ready_o=0 while valid_o=1 & ready_i=0.
  - The output sequence equals the input sequence with no loss or duplication.
  - 1 sample/cycle once ready_i is high.
- Retrigger: gate low at level 200 (RELEASE, release=50), then high after one tick at 150 -> ATTACK from 150; next tick gives 150+attack.
- Boundaries:
  - attack_step=0 -> 255 and DECAY one cycle after rise.
  - sustain=200 entering DECAY at 255 with decay=100 -> 200, SUSTAIN.
  - gate fall on the ATTACK saturation cycle -> RELEASE with level 255.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: envelope state encoding used by the ADSR stage
// and by anything that decodes its debug state output.
package audio_pkg;

    localparam int ENV_STATE_W = 3;

    typedef enum logic [ENV_STATE_W-1:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

endpackage

// File: rtl/env_tick_gen.sv
// Free-running divider producing a one-cycle tick every tick_div_p clocks.
// Reusable by any stage that needs a slow time base.
module env_tick_gen #(
    parameter int tick_div_p = 12000
) (
    input  logic clk_i,
    input  logic reset_n_i,
    output logic tick_o
);

    localparam int cnt_w_c = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
    localparam logic [cnt_w_c-1:0] last_c = cnt_w_c'(tick_div_p - 1);

    logic [cnt_w_c-1:0] count_q;

    assign tick_o = (count_q == last_c);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (tick_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + cnt_w_c'(1);
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Gated ADSR amplitude envelope applied to a signed sample stream, with a
// single registered valid/ready output stage toward the DAC.
module adsr_envelope
    import audio_pkg::*;
#(
    parameter int width_p     = 12,
    parameter int env_width_p = 8,
    parameter int tick_div_p  = 12000
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       gate_i,
    input  logic [env_width_p-1:0]     attack_step_i,
    input  logic [env_width_p-1:0]     decay_step_i,
    input  logic [env_width_p-1:0]     sustain_level_i,
    input  logic [env_width_p-1:0]     release_step_i,
    input  logic                       valid_i,
    input  logic signed [width_p-1:0]  data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic signed [width_p-1:0]  data_o,
    input  logic                       ready_i,
    output logic [ENV_STATE_W-1:0]     env_state_o,
    output logic [env_width_p-1:0]     env_level_o
);

    localparam logic [env_width_p-1:0] max_level_c = '1;
    localparam int prod_w_c = width_p + env_width_p;

    env_state_e               state_q, state_n;
    logic [env_width_p-1:0]   level_q, level_n;
    logic                     gate_q;
    logic                     tick;
    logic                     rise, fall;
    logic [env_width_p:0]     attack_sum;
    logic [env_width_p:0]     decay_floor;
    logic signed [prod_w_c-1:0] product;
    logic signed [width_p-1:0]  data_scaled;

    env_tick_gen #(
        .tick_div_p (tick_div_p)
    ) u_tick_gen (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .tick_o    (tick)
    );

    assign rise        = gate_i & ~gate_q;
    assign fall        = ~gate_i & gate_q;
    assign attack_sum  = {1'b0, level_q} + {1'b0, attack_step_i};
    assign decay_floor = {1'b0, sustain_level_i} + {1'b0, decay_step_i};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ENV_IDLE;
            level_q <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            level_q <= level_n;
            gate_q  <= gate_i;
        end
    end

    // Level update comes first; gate edges then override only the next state,
    // so a tick landing on the same cycle as an edge still moves the level.
    always_comb begin
        state_n = state_q;
        level_n = level_q;
        case (state_q)
            ENV_IDLE: begin
                level_n = '0;
                if (rise) state_n = ENV_ATTACK;
            end
            ENV_ATTACK: begin
                if (attack_step_i == '0) begin
                    level_n = max_level_c;
                    state_n = ENV_DECAY;
                end else if (tick) begin
                    if (attack_sum >= {1'b0, max_level_c}) begin
                        level_n = max_level_c;
                        state_n = ENV_DECAY;
                    end else begin
                        level_n = attack_sum[env_width_p-1:0];
                    end
                end
            end
            ENV_DECAY: begin
                if (decay_step_i == '0 || sustain_level_i >= level_q) begin
                    level_n = sustain_level_i;
                    state_n = ENV_SUSTAIN;
                end else if (tick) begin
                    if ({1'b0, level_q} <= decay_floor) begin
                        level_n = sustain_level_i;
                        state_n = ENV_SUSTAIN;
                    end else begin
                        level_n = level_q - decay_step_i;
                    end
                end
            end
            ENV_SUSTAIN: begin
                level_n = sustain_level_i;
            end
            ENV_RELEASE: begin
                if (release_step_i == '0) begin
                    level_n = '0;
                    state_n = ENV_IDLE;
                end else if (tick) begin
                    if (level_q <= release_step_i) begin
                        level_n = '0;
                        state_n = ENV_IDLE;
                    end else begin
                        level_n = level_q - release_step_i;
                    end
                end
            end
            default: begin
                level_n = '0;
                state_n = ENV_IDLE;
            end
        endcase

        if (fall && (state_q inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN})) begin
            state_n = ENV_RELEASE;
        end
        if (rise && state_q == ENV_RELEASE) begin
            state_n = ENV_ATTACK;
        end
    end

    // The true product always fits in width_p+env_width_p signed bits since
    // the level is strictly below 2^env_width_p, so the extra guard bit is dropped.
    assign product     = prod_w_c'(data_i) * prod_w_c'($signed({1'b0, level_q}));
    assign data_scaled = width_p'(product >>> env_width_p);

    assign ready_o = ~valid_o | ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (valid_i && ready_o) begin
            valid_o <= 1'b1;
            data_o  <= data_scaled;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    assign env_state_o = state_q;
    assign env_level_o = level_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with a 4-cycle tick: reset, full ADSR
// cycle, scaling, backpressure, retrigger and zero-step/edge-collision cases.
module tb_adsr_envelope;

    localparam int width_p     = 12;
    localparam int env_width_p = 8;
    localparam int tick_div_p  = 4;

    logic                      clk_i = 1'b0;
    logic                      reset_n_i;
    logic                      gate_i;
    logic [env_width_p-1:0]    attack_step_i;
    logic [env_width_p-1:0]    decay_step_i;
    logic [env_width_p-1:0]    sustain_level_i;
    logic [env_width_p-1:0]    release_step_i;
    logic                      valid_i;
    logic signed [width_p-1:0] data_i;
    logic                      ready_o;
    logic                      valid_o;
    logic signed [width_p-1:0] data_o;
    logic                      ready_i;
    logic [2:0]                env_state_o;
    logic [env_width_p-1:0]    env_level_o;

    int checks_total  = 0;
    int checks_passed = 0;

    adsr_envelope #(
        .width_p     (width_p),
        .env_width_p (env_width_p),
        .tick_div_p  (tick_div_p)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .gate_i          (gate_i),
        .attack_step_i   (attack_step_i),
        .decay_step_i    (decay_step_i),
        .sustain_level_i (sustain_level_i),
        .release_step_i  (release_step_i),
        .valid_i         (valid_i),
        .data_i          (data_i),
        .ready_o         (ready_o),
        .valid_o         (valid_o),
        .data_o          (data_o),
        .ready_i         (ready_i),
        .env_state_o     (env_state_o),
        .env_level_o     (env_level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_level_change(input logic [env_width_p-1:0] from, input int budget);
        for (int n = 0; n < budget && env_level_o == from; n++) step();
    endtask

    task automatic check_env(input string tag, input int state, input int level);
        check_output({tag, "_state"}, 32'(env_state_o), state);
        check_output({tag, "_level"}, 32'(env_level_o), level);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int decay_exp [8] = '{239, 223, 207, 191, 175, 159, 143, 128};
        int release_exp [4] = '{96, 64, 32, 0};
        int samples [8] = '{300, -700, 5, -1, 2047, -2048, 1000, -333};
        int scoreboard [$];
        int sent, recv, expv;
        logic signed [width_p-1:0] held;
        bit have_held;

        reset_n_i = 1'b0;  gate_i = 1'b0;  valid_i = 1'b0;  data_i = '0;  ready_i = 1'b0;
        attack_step_i = 8'd64;  decay_step_i = 8'd16;
        sustain_level_i = 8'd128;  release_step_i = 8'd32;

        // Reset values before any clock edge
        #2;
        check_output("rst_valid", 32'(valid_o), 0);
        check_output("rst_data", 32'(data_o), 0);
        check_output("rst_ready", 32'(ready_o), 1);
        check_env("rst", 0, 0);

        // Async reset mid-ATTACK with a held output sample
        step();
        reset_n_i = 1'b1;  gate_i = 1'b1;
        repeat (4) step();
        check_env("pre_rst", 1, 64);
        valid_i = 1'b1;  data_i = 12'sd100;
        step();
        valid_i = 1'b0;
        check_output("pre_rst_valid", 32'(valid_o), 1);
        check_output("pre_rst_data", 32'(data_o), 25);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_output("async_rst_valid", 32'(valid_o), 0);
        check_output("async_rst_data", 32'(data_o), 0);
        check_output("async_rst_ready", 32'(ready_o), 1);
        check_env("async_rst", 0, 0);
        gate_i = 1'b0;  ready_i = 1'b1;
        step();

        // Full ADSR cycle, one level step per 4 clocks
        reset_n_i = 1'b1;  gate_i = 1'b1;
        repeat (4) step();
        check_env("atk0", 1, 64);
        repeat (4) step();
        check_env("atk1", 1, 128);
        repeat (4) step();
        check_env("atk2", 1, 192);
        repeat (4) step();
        check_env("atk_sat", 2, 255);
        for (int i = 0; i < 8; i++) begin
            repeat (4) step();
            check_output("decay_level", 32'(env_level_o), decay_exp[i]);
        end
        check_output("decay_to_sus", 32'(env_state_o), 3);
        repeat (4) step();
        check_env("sustain", 3, 128);
        gate_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (4) step();
            check_output("release_level", 32'(env_level_o), release_exp[i]);
        end
        check_output("release_to_idle", 32'(env_state_o), 0);

        // Zero attack step: full scale and DECAY one cycle after entering ATTACK
        attack_step_i = 8'd0;  sustain_level_i = 8'd255;  gate_i = 1'b1;
        step();
        check_env("zatk_rise", 1, 0);
        step();
        check_env("zatk_max", 2, 255);
        step();
        check_env("zatk_sus", 3, 255);

        // Scaling at level 255, 128 and 0
        valid_i = 1'b1;  data_i = 12'sd2047;
        step();
        check_output("scale_pos", 32'(data_o), 2039);
        data_i = -12'sd2048;
        step();
        check_output("scale_neg", 32'(data_o), -2040);
        valid_i = 1'b0;  sustain_level_i = 8'd128;
        step();
        check_output("scale_drain", 32'(valid_o), 0);
        valid_i = 1'b1;  data_i = -12'sd1;
        step();
        check_output("scale_floor", 32'(data_o), -1);
        valid_i = 1'b0;  gate_i = 1'b0;  release_step_i = 8'd0;
        step();
        step();
        check_env("zrel_idle", 0, 0);
        valid_i = 1'b1;  data_i = 12'sd1234;
        step();
        check_output("scale_zero", 32'(data_o), 0);
        valid_i = 1'b0;
        step();

        // Backpressure: continuous valid, downstream stalled 5 cycles
        sustain_level_i = 8'd255;  gate_i = 1'b1;
        repeat (3) step();
        check_env("bp_setup", 3, 255);
        sent = 0;  recv = 0;  have_held = 1'b0;  held = '0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            ready_i = (cyc >= 5);
            valid_i = (sent < 8);
            data_i  = (sent < 8) ? 12'(samples[sent]) : '0;
            #1;
            if (valid_o && !ready_i) begin
                check_output("bp_ready_low", 32'(ready_o), 0);
                if (have_held) check_output("bp_hold", 32'(data_o), 32'(held));
                held = data_o;
                have_held = 1'b1;
            end
            if (ready_i) check_output("bp_rate", 32'(valid_o), 1);
            if (valid_o && ready_i) begin
                expv = (scoreboard.size() != 0) ? scoreboard.pop_front() : 32'h7fff_ffff;
                check_output("bp_data", 32'(data_o), expv);
                recv++;
            end
            if (valid_i && ready_o) begin
                scoreboard.push_back((samples[sent] * 255) >>> 8);
                sent++;
            end
            step();
        end
        valid_i = 1'b0;  ready_i = 1'b1;
        check_output("bp_count", recv, 8);
        check_output("bp_leftover", scoreboard.size(), 0);

        // Retrigger from RELEASE keeps the current level
        sustain_level_i = 8'd200;  release_step_i = 8'd50;  attack_step_i = 8'd100;
        gate_i = 1'b0;
        step();
        check_env("retrig_rel", 4, 200);
        wait_level_change(8'd200, 6);
        check_env("retrig_tick", 4, 150);
        gate_i = 1'b1;
        step();
        check_env("retrig_atk", 1, 150);
        wait_level_change(8'd150, 6);
        check_env("retrig_next", 1, 250);

        // Decay overshoot below sustain clamps to sustain
        decay_step_i = 8'd100;
        wait_level_change(8'd250, 6);
        check_env("clamp_decay", 2, 255);
        wait_level_change(8'd255, 6);
        check_env("clamp_sus", 3, 200);

        // Gate fall on the ATTACK saturation tick
        gate_i = 1'b0;  release_step_i = 8'd0;
        step();
        step();
        check_env("col_idle", 0, 0);
        attack_step_i = 8'd128;  gate_i = 1'b1;
        wait_level_change(8'd0, 10);
        check_env("col_atk", 1, 128);
        repeat (3) step();
        gate_i = 1'b0;
        step();
        check_env("col_fall", 4, 255);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
